// File: rtl/sr_write_arbiter_pkg.sv
// Shared definitions for the SR-bank write-port arbiter: FSM encoding,
// requester indices and default sizes.
package sr_write_arbiter_pkg;

   localparam int NUM_REQ_DEF      = 3;
   localparam int SEL_W_DEF        = 4;
   localparam int DATA_W_DEF       = 48;
   localparam int LOCK_TIMEOUT_DEF = 16;

   localparam int REQ_WB   = 0;
   localparam int REQ_TRAP = 1;
   localparam int REQ_DBG  = 2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   // Round-robin successor of a requester index.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/sr_write_arbiter_if.sv
// Requester-side and SR-bank-side signals of the write arbiter, bundled with
// a slave modport for the arbiter and a master modport for the requesters.
interface sr_write_arbiter_if
   import sr_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int OWNER_W = $clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0]        iw_req_valid;
   logic [NUM_REQ-1:0]        iw_req_lock;
   logic [NUM_REQ*SEL_W-1:0]  iw_req_addr;
   logic [NUM_REQ*DATA_W-1:0] iw_req_data;
   logic [NUM_REQ-1:0]        ow_req_ready;
   logic [SEL_W-1:0]          ow_write_addr;
   logic [DATA_W-1:0]         ow_write_data;
   logic                      ow_write_enable;
   logic [OWNER_W-1:0]        ow_lock_owner;
   logic                      ow_locked;
   logic                      ow_lock_abort;

   modport slave (
      input  iw_req_valid, iw_req_lock, iw_req_addr, iw_req_data,
      output ow_req_ready, ow_write_addr, ow_write_data, ow_write_enable,
      output ow_lock_owner, ow_locked, ow_lock_abort
   );

   modport master (
      output iw_req_valid, iw_req_lock, iw_req_addr, iw_req_data,
      input  ow_req_ready, ow_write_addr, ow_write_data, ow_write_enable,
      input  ow_lock_owner, ow_locked, ow_lock_abort
   );

endinterface

// File: rtl/sr_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning cyclically
// from ptr, returned as a one-hot grant and a binary index.
module rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   function automatic int wrap_add(input int a, input int b);
      return (a + b >= N) ? a + b - N : a + b;
   endfunction

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int off = 0; off < N; off++) begin
         if (!found && req[wrap_add(int'(ptr), off)]) begin
            grant[wrap_add(int'(ptr), off)] = 1'b1;
            idx   = IDX_W'(wrap_add(int'(ptr), off));
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_write_arbiter.sv
// Round-robin arbiter for the single SR-bank write port with locked
// multi-beat sequences, lock timeout and a registered write port.
module sr_write_arbiter
   import sr_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = NUM_REQ_DEF,
   parameter int SEL_W        = SEL_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
   input logic               iw_clk,
   input logic               iw_rst,
   sr_write_arbiter_if.slave bus
);

   localparam int OWNER_W = $clog2(NUM_REQ);
   localparam int CNT_W   = $clog2(LOCK_TIMEOUT);

   arb_state_e          state_reg;
   logic [OWNER_W-1:0]  r_ptr_reg;
   logic [OWNER_W-1:0]  owner_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic                write_enable_reg;
   logic [SEL_W-1:0]    write_addr_reg;
   logic [DATA_W-1:0]   write_data_reg;

   logic [NUM_REQ-1:0]  pick_grant;
   logic [OWNER_W-1:0]  pick_idx;
   logic                pick_found;
   logic [NUM_REQ-1:0]  grant_vec;
   logic [OWNER_W-1:0]  gnt_idx;
   logic                owner_valid;
   logic                xfer;
   logic                timeout_hit;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (OWNER_W)
   ) u_pick (
      .req   (bus.iw_req_valid),
      .ptr   (r_ptr_reg),
      .grant (pick_grant),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign owner_valid = bus.iw_req_valid[owner_reg];

   // Readies are gated by reset directly so they drop the moment reset rises.
   always_comb begin
      grant_vec = '0;
      if (!iw_rst) begin
         if (state_reg == ST_IDLE) begin
            grant_vec = pick_grant;
         end else begin
            grant_vec[owner_reg] = owner_valid;
         end
      end
   end

   assign gnt_idx     = (state_reg == ST_LOCKED) ? owner_reg : pick_idx;
   assign xfer        = (state_reg == ST_LOCKED) ? (owner_valid && !iw_rst)
                                                 : (pick_found && !iw_rst);
   assign timeout_hit = (state_reg == ST_LOCKED) && !owner_valid &&
                        (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1));

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state_reg        <= ST_IDLE;
         r_ptr_reg        <= '0;
         owner_reg        <= '0;
         cnt_reg          <= '0;
         write_enable_reg <= 1'b0;
         write_addr_reg   <= '0;
         write_data_reg   <= '0;
      end else begin
         write_enable_reg <= xfer;
         if (xfer) begin
            write_addr_reg <= bus.iw_req_addr[int'(gnt_idx)*SEL_W +: SEL_W];
            write_data_reg <= bus.iw_req_data[int'(gnt_idx)*DATA_W +: DATA_W];
         end
         case (state_reg)
            ST_IDLE: begin
               if (xfer) begin
                  r_ptr_reg <= OWNER_W'(rr_next(int'(gnt_idx), NUM_REQ));
                  if (bus.iw_req_lock[gnt_idx]) begin
                     state_reg <= ST_LOCKED;
                     owner_reg <= gnt_idx;
                     cnt_reg   <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               // r_ptr already points past the owner, so release is fair.
               if (xfer) begin
                  if (bus.iw_req_lock[owner_reg]) begin
                     cnt_reg <= '0;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end else if (timeout_hit) begin
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.ow_req_ready    = grant_vec;
   assign bus.ow_write_enable = write_enable_reg;
   assign bus.ow_write_addr   = write_addr_reg;
   assign bus.ow_write_data   = write_data_reg;
   assign bus.ow_locked       = (state_reg == ST_LOCKED);
   assign bus.ow_lock_owner   = owner_reg;
   // Abort is asserted during the final idle cycle of the owner, the same
   // cycle in which the release decision is taken.
   assign bus.ow_lock_abort   = timeout_hit;

endmodule

// File: tb/tb_sr_write_arbiter.sv
// Directed bench for sr_write_arbiter: expected readies per cycle, expected
// writes queued on grant and compared one cycle later at the SR write port.
module tb_sr_write_arbiter;
   import sr_write_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int SW = 4;
   localparam int DW = 48;
   localparam int TO = 16;

   logic iw_clk = 1'b0;
   logic iw_rst = 1'b1;
   always #5 iw_clk = ~iw_clk;

   sr_write_arbiter_if #(.NUM_REQ(N), .SEL_W(SW), .DATA_W(DW)) bus ();

   sr_write_arbiter #(
      .NUM_REQ      (N),
      .SEL_W        (SW),
      .DATA_W       (DW),
      .LOCK_TIMEOUT (TO)
   ) dut (
      .iw_clk (iw_clk),
      .iw_rst (iw_rst),
      .bus    (bus)
   );

   logic [N-1:0]  valid = '0;
   logic [N-1:0]  lock  = '0;
   logic [SW-1:0] addr [N];
   logic [DW-1:0] data [N];

   always_comb begin
      bus.iw_req_valid = valid;
      bus.iw_req_lock  = lock;
      bus.iw_req_addr  = '0;
      bus.iw_req_data  = '0;
      for (int i = 0; i < N; i++) begin
         bus.iw_req_addr[i*SW +: SW] = addr[i];
         bus.iw_req_data[i*DW +: DW] = data[i];
      end
   end

   int checks_total  = 0;
   int checks_passed = 0;

   logic [SW+DW-1:0] wq [$];
   logic             exp_we_pend = 1'b0;
   logic [SW-1:0]    last_addr   = '0;
   logic [DW-1:0]    last_data   = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   // One clock cycle: check the write port for the previous cycle's beat,
   // check this cycle's readies/lock status, queue the expected write.
   task automatic tick(input string tag, input logic [N-1:0] exp_rdy,
                       input logic exp_locked, input logic [1:0] exp_owner,
                       input logic exp_abort);
      logic [SW+DW-1:0] e;
      @(negedge iw_clk);
      chk({tag, ".we"}, 64'(bus.ow_write_enable), 64'(exp_we_pend));
      if (exp_we_pend) begin
         e = wq.pop_front();
         last_addr = e[SW+DW-1:DW];
         last_data = e[DW-1:0];
         $display("write addr=%h data=%h (%s)", bus.ow_write_addr, bus.ow_write_data, tag);
      end
      chk({tag, ".addr"}, 64'(bus.ow_write_addr), 64'(last_addr));
      chk({tag, ".data"}, 64'(bus.ow_write_data), 64'(last_data));
      chk({tag, ".ready"}, 64'(bus.ow_req_ready), 64'(exp_rdy));
      chk({tag, ".locked"}, 64'(bus.ow_locked), 64'(exp_locked));
      chk({tag, ".abort"}, 64'(bus.ow_lock_abort), 64'(exp_abort));
      if (exp_locked) chk({tag, ".owner"}, 64'(bus.ow_lock_owner), 64'(exp_owner));
      exp_we_pend = |exp_rdy;
      for (int k = 0; k < N; k++) begin
         if (exp_rdy[k]) wq.push_back({addr[k], data[k]});
      end
      @(posedge iw_clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         addr[i] = SW'(i);
         data[i] = DW'(48'h1000 * (i + 1));
      end

      // Reset values, with a request pending to show ready is held low.
      valid = 3'b010;
      #2;
      chk("rst.ready", 64'(bus.ow_req_ready), 64'(0));
      chk("rst.we", 64'(bus.ow_write_enable), 64'(0));
      chk("rst.addr", 64'(bus.ow_write_addr), 64'(0));
      chk("rst.data", 64'(bus.ow_write_data), 64'(0));
      chk("rst.locked", 64'(bus.ow_locked), 64'(0));
      chk("rst.owner", 64'(bus.ow_lock_owner), 64'(0));
      chk("rst.abort", 64'(bus.ow_lock_abort), 64'(0));
      @(posedge iw_clk);
      #1;
      iw_rst = 1'b0;

      // Single request from the trap unit.
      addr[REQ_TRAP] = 4'h3;
      data[REQ_TRAP] = 48'h0000_0000_1234;
      tick("single", 3'b010, 1'b0, 2'd0, 1'b0);
      valid = 3'b000;
      tick("single_wr", 3'b000, 1'b0, 2'd0, 1'b0);
      valid = 3'b100;
      addr[REQ_DBG] = 4'h7;
      data[REQ_DBG] = 48'h0000_0000_5678;
      tick("dbg", 3'b100, 1'b0, 2'd0, 1'b0);
      valid = 3'b000;
      tick("dbg_wr", 3'b000, 1'b0, 2'd0, 1'b0);
      tick("idle_hold", 3'b000, 1'b0, 2'd0, 1'b0);

      // Round robin with all three requesters continuously valid.
      valid = 3'b111;
      addr[REQ_WB] = 4'h1; addr[REQ_TRAP] = 4'h2; addr[REQ_DBG] = 4'h4;
      for (int i = 0; i < 6; i++) begin
         tick("rr", 3'(1 << (i % 3)), 1'b0, 2'd0, 1'b0);
         data[i % 3] = data[i % 3] + 48'h1;
      end
      valid = 3'b000;
      tick("rr_drain", 3'b000, 1'b0, 2'd0, 1'b0);

      // Atomic trap sequence while writeback keeps requesting.
      valid = 3'b001;
      tick("pre_trap", 3'b001, 1'b0, 2'd0, 1'b0);
      valid = 3'b011;
      lock[REQ_TRAP] = 1'b1;
      addr[REQ_TRAP] = 4'h5;
      data[REQ_TRAP] = 48'hABCD_0000_0100;
      tick("trap1", 3'b010, 1'b0, 2'd0, 1'b0);
      lock[REQ_TRAP] = 1'b0;
      addr[REQ_TRAP] = 4'h9;
      data[REQ_TRAP] = 48'hABCD_0000_0200;
      tick("trap2", 3'b010, 1'b1, 2'd1, 1'b0);
      valid = 3'b001;
      tick("trap_after", 3'b001, 1'b0, 2'd0, 1'b0);
      valid = 3'b000;
      tick("trap_drain", 3'b000, 1'b0, 2'd0, 1'b0);

      // Lock timeout: debug port locks then goes silent.
      valid = 3'b101;
      lock[REQ_DBG] = 1'b1;
      tick("to_lock", 3'b100, 1'b0, 2'd0, 1'b0);
      valid = 3'b001;
      for (int i = 1; i <= TO; i++) begin
         tick("to_idle", 3'b000, 1'b1, 2'd2, i == TO);
      end
      tick("to_after", 3'b001, 1'b0, 2'd0, 1'b0);

      // Owner returns exactly on the last idle cycle: beat wins, no abort.
      valid = 3'b101;
      tick("save_lock", 3'b100, 1'b0, 2'd0, 1'b0);
      valid = 3'b001;
      for (int i = 1; i < TO; i++) begin
         tick("save_idle", 3'b000, 1'b1, 2'd2, 1'b0);
      end
      valid = 3'b101;
      lock[REQ_DBG] = 1'b0;
      data[REQ_DBG] = 48'h0000_FEED_0000;
      tick("save_beat", 3'b100, 1'b1, 2'd2, 1'b0);
      valid = 3'b001;
      tick("save_after", 3'b001, 1'b0, 2'd0, 1'b0);
      valid = 3'b000;
      tick("save_drain", 3'b000, 1'b0, 2'd0, 1'b0);

      // Reset while locked with a write in flight.
      valid = 3'b001;
      lock[REQ_WB] = 1'b1;
      tick("rl_lock", 3'b001, 1'b0, 2'd0, 1'b0);
      valid = 3'b011;
      #1;
      chk("rl_inflight.we", 64'(bus.ow_write_enable), 64'(1));
      chk("rl_inflight.locked", 64'(bus.ow_locked), 64'(1));
      iw_rst = 1'b1;
      #1;
      chk("rl_async.we", 64'(bus.ow_write_enable), 64'(0));
      chk("rl_async.locked", 64'(bus.ow_locked), 64'(0));
      chk("rl_async.ready", 64'(bus.ow_req_ready), 64'(0));
      wq.delete();
      exp_we_pend = 1'b0;
      last_addr = '0;
      last_data = '0;
      @(posedge iw_clk);
      #1;
      iw_rst = 1'b0;
      lock = '0;
      valid = 3'b111;
      tick("rl_rr0", 3'b001, 1'b0, 2'd0, 1'b0);
      tick("rl_rr1", 3'b010, 1'b0, 2'd0, 1'b0);
      tick("rl_rr2", 3'b100, 1'b0, 2'd0, 1'b0);
      valid = 3'b000;
      tick("end_drain", 3'b000, 1'b0, 2'd0, 1'b0);
      tick("end_idle", 3'b000, 1'b0, 2'd0, 1'b0);
      chk("sb_empty", 64'(wq.size()), 64'(0));

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/sr_write_arbiter.md
Name: sr_write_arbiter

Overview:
- Shares the single write port of the special-register file (SR bank) between NUM_REQ requesters.
- Typical requesters: pipeline writeback, trap/interrupt entry unit, debug port.
- Grants one write per cycle with round-robin fairness.
- Supports locked multi-beat sequences, so a trap entry can write several SRs atomically, e.g. saved PC then SSP.
- The write port is driven from registered outputs that feed the SR bank directly.

Parameters:
- NUM_REQ, 3: number of requesters; legal range 2..8.
- SEL_W, 4: SR index width; equals HBIT_TGT_SR+1.
- DATA_W, 48: SR data width; equals HBIT_ADDR+1.
- LOCK_TIMEOUT, 16: idle cycles a lock owner may hold the port without issuing a beat before the lock is force-released; legal range ≥2.

Ports:
- iw_clk  in  1  clock.
- iw_rst  in  1  asynchronous, active-high reset.
- iw_req_valid  in  NUM_REQ  per-requester write request.
- iw_req_lock  in  NUM_REQ  per-requester "more beats follow, keep grant".
- iw_req_addr  in  NUM_REQ*SEL_W  flattened SR indices; requester i occupies bits [i*SEL_W +: SEL_W].
- iw_req_data  in  NUM_REQ*DATA_W  flattened write data; same packing as iw_req_addr.
- ow_req_ready  out  NUM_REQ  one-hot grant; a beat transfers when valid & ready.
- ow_write_addr  out  SEL_W  to SR bank write address.
- ow_write_data  out  DATA_W  to SR bank write data.
- ow_write_enable  out  1  to SR bank write enable.
- ow_lock_owner  out  clog2(NUM_REQ)  index of current lock owner; valid only while ow_locked=1.
- ow_locked  out  1  port is locked.
- ow_lock_abort  out  1  one-cycle pulse on forced release after timeout.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, r_ptr=0, timeout counter=0.
  - ow_write_enable=0, ow_write_addr=0, ow_write_data=0.
  - ow_locked=0, ow_lock_owner=0, ow_lock_abort=0.
  - ow_req_ready=0 while iw_rst is high.
- ow_req_ready is combinational from iw_req_valid, state, r_ptr and owner. It is at most one-hot and is never asserted for a requester whose valid is low.
- IDLE state:
  - Grant the first valid requester scanning cyclically from r_ptr (r_ptr, r_ptr+1, ... mod NUM_REQ).
  - On transfer from requester k: r_ptr <= (k+1) mod NUM_REQ.
  - If iw_req_lock[k]=1 on that beat: state <= LOCKED, owner <= k, counter <= 0.
- LOCKED state:
  - Only the owner can be granted, whenever its valid is high; all other readies are 0.
  - Owner beat with lock=1: stay LOCKED, counter <= 0.
  - Owner beat with lock=0: state <= IDLE.
  - r_ptr stays at owner+1 throughout, so the owner gets no extra priority after release.
  - Owner valid low: counter increments. When the counter reaches LOCK_TIMEOUT-1 with the owner still idle, state <= IDLE and ow_lock_abort pulses for one cycle.
  - If owner valid rises in the same cycle the counter reaches LOCK_TIMEOUT-1, the beat transfers and the timeout does not fire.
- Write port, fixed 1-cycle latency:
  - A transfer in cycle N produces ow_write_enable=1 with the captured addr/data in cycle N+1.
  - No transfer in cycle N gives ow_write_enable=0 in N+1; addr/data hold their last value.
  - Throughput is 1 write per cycle; back-to-back beats from one or different requesters are allowed.
- ow_locked/ow_lock_owner reflect the registered state, i.e. they are high from the cycle after the locking beat.
- A requester must hold addr/data stable while valid && !ready. Dropping valid before ready is permitted outside LOCKED; the request is simply withdrawn.
- Reset mid-sequence:
  - Lock released, pending outputs cleared, no write issued.
  - Partially written SRs are not rolled back; the SR bank resets independently.
- Lock asserted on a withdrawn (non-transferred) request has no effect.

Decomposition:
- Shared package/header, alongside sizes/sr headers:
  - state encoding IDLE=1'b0 and LOCKED=1'b1.
  - requester index constants REQ_WB=0, REQ_TRAP=1, REQ_DBG=2.
- One natural sub-module: rr_pick. It is a combinational round-robin picker taking the request vector and pointer, and returning a one-hot grant plus a binary index. It is reusable for the GPR-file port arbiter.

Test Plan:
- Reset value, single request:
  - Stimulus: after reset, req1 valid, addr=4'h3, data=48'h0000_0000_1234.
  - Required: ready=3'b010 same cycle; next cycle write_enable=1, addr=3, data=0x1234.
  - Idle cycles: write_enable=0.
- Round robin:
  - Stimulus: all three requesters continuously valid, lock=0.
  - Required: grant order 0,1,2,0,1,2; write_enable high every cycle.
- Atomic trap sequence:
  - Stimulus: req1 beats (addr 5, lock=1) then (addr SSP, lock=0), with req0 valid throughout.
  - Required: req0 ready=0 until after the second beat; ow_locked=1 for exactly the cycle after the first beat; req0 granted next.
- Lock timeout:
  - Stimulus: req2 locks then drops valid for 16 cycles while req0 is valid.
  - Required: ow_lock_abort pulses once on the 16th idle cycle; req0 granted the following cycle.
- Reset mid-lock:
  - Stimulus: assert iw_rst while LOCKED with a write in flight.
  - Required: ow_write_enable, ow_locked and ow_req_ready drop immediately (asynchronously).
  - After release: arbitration restarts from requester 0.
